// File: rtl/vec_mac.sv
// vec_mac: signed dot-product engine for one matrix row.
// Chunks of N elements are consumed NUM_MACS lanes per cycle.
module vec_mac #(
  parameter int N        = 8,
  parameter int WIDTH    = 16,
  parameter int NUM_MACS = 2,
  parameter int ACC_W    = 2*WIDTH+16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             row_size,
  input  logic                    vec_valid,
  output logic                    vec_ready,
  input  logic [N*WIDTH-1:0]      vector_A,
  input  logic [N*WIDTH-1:0]      vector_B,
  output logic signed [ACC_W-1:0] result,
  output logic [31:0]             counter,
  output logic                    done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [N*WIDTH-1:0]      a_q, b_q;
  logic [IW-1:0]           idx;
  logic [31:0]             size_q, cnt_q;
  logic signed [ACC_W-1:0] acc_q;

  logic signed [ACC_W-1:0]   mac_sum;
  logic [31:0]               cnt_add;
  logic [31:0]               cnt_nx;
  logic signed [WIDTH-1:0]   lane_a, lane_b;
  logic signed [2*WIDTH-1:0] prod;
  logic                      last;

  // Lanes past row_size are masked; counter equals the
  // global index of lane idx while lanes remain valid.
  always_comb begin
    mac_sum = '0;
    cnt_add = '0;
    lane_a  = '0;
    lane_b  = '0;
    prod    = '0;
    for (int j = 0; j < NUM_MACS; j++) begin
      lane_a = a_q[(int'(idx) + j)*WIDTH +: WIDTH];
      lane_b = b_q[(int'(idx) + j)*WIDTH +: WIDTH];
      prod   = lane_a * lane_b;
      if (({1'b0, cnt_q} + 33'(j)) < {1'b0, size_q}) begin
        mac_sum = mac_sum + ACC_W'(prod);
        cnt_add = cnt_add + 32'd1;
      end
    end
  end

  assign cnt_nx = cnt_q + cnt_add;
  assign last   = (idx == IW'(N - NUM_MACS));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (row_size == 32'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (vec_valid) begin
          state_nx = MAC;
        end
      end
      MAC: begin
        if (last) begin
          state_nx = (cnt_nx >= size_q) ? DONE : LOAD;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      size_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            size_q <= row_size;
            cnt_q  <= '0;
            acc_q  <= '0;
          end
        end
        LOAD: begin
          if (vec_valid) begin
            a_q <= vector_A;
            b_q <= vector_B;
            idx <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_q + mac_sum;
          cnt_q <= cnt_nx;
          idx   <= idx + IW'(NUM_MACS);
        end
        default: ;
      endcase
    end
  end

  assign vec_ready = (state == LOAD);
  assign done      = (state == DONE);
  assign result    = acc_q;
  assign counter   = cnt_q;

endmodule

// File: tb/tb_vec_mac.sv
// tb_vec_mac: directed rows with a scoreboard of expected
// result, counter and done cycle per accepted start.
module tb_vec_mac;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int M  = 2;
  localparam int AW = 2*W+16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   row_size = '0;
  logic          vec_valid = 1'b0;
  logic          vec_ready;
  logic [N*W-1:0] vector_A = '0;
  logic [N*W-1:0] vector_B = '0;
  logic [AW-1:0] result;
  logic [31:0]   counter;
  logic          done;

  vec_mac #(.N(N), .WIDTH(W), .NUM_MACS(M), .ACC_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .row_size  (row_size),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vector_A  (vector_A),
    .vector_B  (vector_B),
    .result    (result),
    .counter   (counter),
    .done      (done)
  );

  typedef struct {
    logic [AW-1:0] res;
    logic [31:0]   cnt;
    int            due;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ea[64];
  int   eb[64];
  bit   chk_low = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // Scoreboard side: pop on every done pulse.
  initial forever begin
    @(posedge clk);
    #2;
    if (chk_low) begin
      check("done_one_cycle", 64'(done), 64'd0);
      chk_low = 1'b0;
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        cur = sb.pop_front();
        check("result", 64'(result), 64'(cur.res));
        check("counter", 64'(counter), 64'(cur.cnt));
        check("done_cycle", 64'(cyc), 64'(cur.due));
        chk_low = 1'b1;
      end
    end
  end

  task automatic drive(int c);
    int ta, tb;
    for (int k = 0; k < N; k++) begin
      ta = ea[c*N + k];
      tb = eb[c*N + k];
      vector_A[k*W +: W] = ta[W-1:0];
      vector_B[k*W +: W] = tb[W-1:0];
    end
  endtask

  task automatic fill(int a, int b, bit ramp);
    for (int i = 0; i < 64; i++) begin
      ea[i] = ramp ? (i % N) : a;
      eb[i] = b;
    end
  endtask

  task automatic wait_ready(output bit ok);
    int k = 0;
    while (vec_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    ok = (vec_ready === 1'b1);
    if (!ok) fail_now("ready_timeout");
  endtask

  task automatic run_row(int size, bit stall, bit mid_start);
    int     nch = (size + N - 1) / N;
    int     k;
    bit     ok;
    longint s = 0;
    exp_t   e;
    for (int i = 0; i < size; i++) begin
      s += longint'(ea[i]) * longint'(eb[i]);
    end
    e.res = s[AW-1:0];
    e.cnt = size;
    @(negedge clk);
    e.due = cyc + 1 + nch*(1 + N/M) + (stall ? 3 : 0);
    sb.push_back(e);
    start = 1'b1;
    row_size = size;
    drive(0);
    vec_valid = (nch > 0);
    @(negedge clk);
    start = 1'b0;
    if (size == 0) check("zero_ready_done", 64'(vec_ready), 64'd0);
    for (int c = 0; c < nch; c++) begin
      drive(c);
      vec_valid = !(stall && c == 1);
      wait_ready(ok);
      if (!ok) begin
        vec_valid = 1'b0;
        sb.delete();
        return;
      end
      if (stall && c == 1) begin
        repeat (3) @(negedge clk);
        vec_valid = 1'b1;
      end
      if (mid_start && c == 1) begin
        start = 1'b1;
        row_size = 32'd3;
      end
      @(negedge clk);
      start = 1'b0;
    end
    vec_valid = 1'b0;
    k = 0;
    while (sb.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      fail_now("done_timeout");
      sb.delete();
    end
    @(negedge clk);
    if (size == 0) check("zero_ready_idle", 64'(vec_ready), 64'd0);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    check("rst_result", 64'(result), 64'd0);
    check("rst_counter", 64'(counter), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(vec_ready), 64'd0);
    rst = 1'b0;

    fill(1, 1, 1'b0);
    run_row(32, 1'b0, 1'b0);

    fill(0, 2, 1'b1);
    run_row(8, 1'b0, 1'b0);

    fill(3, -4, 1'b0);
    run_row(5, 1'b0, 1'b0);

    run_row(0, 1'b0, 1'b0);

    fill(1, 1, 1'b0);
    run_row(16, 1'b1, 1'b1);

    fill(-32768, -32768, 1'b0);
    run_row(3, 1'b0, 1'b0);

    // Abort a 3-chunk row during the MAC of its second chunk.
    fill(1, 1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    row_size = 32'd24;
    drive(0);
    vec_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(ok);
    @(negedge clk);
    drive(1);
    wait_ready(ok);
    @(negedge clk);
    rst = 1'b1;
    vec_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_result", 64'(result), 64'd0);
    check("abort_counter", 64'(counter), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_ready", 64'(vec_ready), 64'd0);
    repeat (30) @(negedge clk);

    run_row(8, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
